// File: rtl/brute_force_pkg.sv
// brute_force_pkg: shared constants, shuffle FSM states and key byte selection
package brute_force_pkg;
  localparam int S_DEPTH = 256;
  localparam int KEY_LENGTH = 3;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ_I,
    ST_WAIT_I,
    ST_CAP_I,
    ST_READ_J,
    ST_WAIT_J,
    ST_CAP_J,
    ST_WRITE_I,
    ST_WRITE_J,
    ST_NEXT,
    ST_DONE
  } shuffle_state_e;
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] k);
    return k == 2'd0 ? key[23:16] : k == 2'd1 ? key[15:8] : key[7:0];
  endfunction
endpackage

// File: rtl/rc4_shuffle_worker.sv
// rc4_shuffle_worker: RC4 key-scheduling swap pass over the 256-byte S memory
module rc4_shuffle_worker
  import brute_force_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int KEY_WIDTH  = 24,
  parameter int KEY_LENGTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_WIDTH-1:0]  secret_key,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  finish
);
  shuffle_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [1:0] k_q, k_d;
  logic j_sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      si_q <= '0;
      sj_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      si_q <= si_d;
      sj_q <= sj_d;
    end
  end
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    si_d = si_q;
    sj_d = sj_q;
    case (state_q)
      ST_IDLE: begin
        state_d = start ? ST_READ_I : ST_IDLE;
        i_d = start ? '0 : i_q;
        j_d = start ? '0 : j_q;
        k_d = start ? '0 : k_q;
      end
      ST_READ_I: state_d = ST_WAIT_I;
      ST_WAIT_I: state_d = ST_CAP_I;
      ST_CAP_I: begin
        si_d = mem_q;
        j_d = j_q + mem_q + key_byte(secret_key, k_q);
        state_d = ST_READ_J;
      end
      ST_READ_J: state_d = ST_WAIT_J;
      ST_WAIT_J: state_d = ST_CAP_J;
      ST_CAP_J: begin
        sj_d = mem_q;
        state_d = ST_WRITE_I;
      end
      ST_WRITE_I: state_d = ST_WRITE_J;
      ST_WRITE_J: state_d = ST_NEXT;
      ST_NEXT: begin
        state_d = i_q == '1 ? ST_DONE : ST_READ_I;
        i_d = i_q == '1 ? i_q : i_q + 1'b1;
        k_d = i_q == '1 ? k_q : k_q == 2'(KEY_LENGTH - 1) ? 2'd0 : k_q + 2'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // j owns the bus from the j read through the second write
  assign j_sel = state_q inside {ST_READ_J, ST_WAIT_J, ST_CAP_J, ST_WRITE_J};
  assign mem_address = state_q == ST_IDLE ? '0 : ADDR_WIDTH'(j_sel ? j_q : i_q);
  assign mem_data = state_q == ST_WRITE_I ? sj_q : state_q == ST_WRITE_J ? si_q : '0;
  assign mem_wren = !reset && (state_q == ST_WRITE_I || state_q == ST_WRITE_J);
  assign finish = !reset && state_q == ST_DONE;
endmodule

// File: tb/tb_rc4_shuffle_worker.sv
// tb_rc4_shuffle_worker: table and random key runs against a software RC4 KSA
module tb_rc4_shuffle_worker;
  typedef logic [7:0] sarr_t [256];
  typedef struct {
    logic [23:0] key;
    bit extra;
    int rst_at;
    bit early;
    int exp_fin;
    int exp_writes;
  } vec_t;
  logic clk = 0, reset = 1, start = 0;
  logic [23:0] secret_key = '0;
  logic [7:0] mem_q, mem_data, mem_address;
  logic mem_wren, finish;
  logic [7:0] s_mem [256];
  bit do_init = 0;
  int n_cmp = 0, n_bad = 0;
  rc4_shuffle_worker dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key), .mem_q(mem_q),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .finish(finish)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (do_init) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= 8'(a);
    end else if (mem_wren) s_mem[mem_address] <= mem_data;
    mem_q <= s_mem[mem_address];
  end
  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void ksa(input logic [23:0] key, output sarr_t s);
    logic [7:0] j, t, kb;
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    j = 0;
    for (int a = 0; a < 256; a++) begin
      kb = 8'(key >> (8 * (2 - a % 3)));
      j = j + s[a] + kb;
      t = s[a];
      s[a] = s[j];
      s[j] = t;
    end
  endfunction
  task automatic init_mem();
    @(negedge clk) do_init = 1;
    @(posedge clk) #1 do_init = 0;
  endtask
  task automatic run(input vec_t v);
    sarr_t exp;
    int cyc, writes, late, fin, bad, limit;
    init_mem();
    secret_key = v.key;
    @(negedge clk) start = 1;
    @(posedge clk) #1 start = 0;
    cyc = 0; writes = 0; late = 0; fin = -1;
    limit = v.rst_at > 0 ? v.rst_at + 2400 : 3000;
    while (cyc < limit && (fin < 0 || v.rst_at > 0)) begin
      if (v.rst_at > 0 && cyc == v.rst_at) reset = 1;
      if (v.rst_at > 0 && cyc == v.rst_at + 2) reset = 0;
      @(posedge clk) #1 cyc++;
      start = v.extra && (cyc == 10 || cyc == 1000);
      if (mem_wren) writes++;
      if (mem_wren && v.rst_at > 0 && cyc > v.rst_at) late++;
      if (finish && fin < 0) fin = cyc;
      if (v.early && cyc == 27) begin
        check(s_mem[2] == 8'd3, "iter2_s2", int'(s_mem[2]), 3);
        check(s_mem[3] == 8'd2, "iter2_s3", int'(s_mem[3]), 2);
        check(s_mem[0] == 8'd0 && s_mem[1] == 8'd1, "iter01_self", int'({s_mem[0], s_mem[1]}), 1);
      end
      if (v.rst_at > 0 && cyc == v.rst_at + 1) begin
        check(!mem_wren, "rst_wren", int'(mem_wren), 0);
        check(mem_address == 8'd0, "rst_addr", int'(mem_address), 0);
      end
    end
    start = 0;
    check(fin == v.exp_fin, "finish_cycle", fin, v.exp_fin);
    if (v.rst_at > 0) begin
      check(late == 0, "writes_after_reset", late, 0);
    end else begin
      check(writes == v.exp_writes, "wren_count", writes, v.exp_writes);
      @(posedge clk) #1 check(!finish, "finish_width", int'(finish), 0);
      ksa(v.key, exp);
      bad = 0;
      for (int a = 0; a < 256; a++) if (s_mem[a] !== exp[a]) bad++;
      check(bad == 0, $sformatf("ksa_key_%06h", v.key), bad, 0);
    end
  endtask
  vec_t tbl [7];
  initial begin
    tbl[0] = '{24'h000000, 0, 0, 1, 2304, 512};
    tbl[1] = '{24'h0249F1, 0, 0, 0, 2304, 512};
    tbl[2] = '{24'h0249F1, 1, 0, 0, 2304, 512};
    tbl[3] = '{24'h0249F1, 0, 500, 0, -1, 0};
    tbl[4] = '{24'h000000, 0, 0, 1, 2304, 512};
    tbl[5] = '{24'h000001, 0, 0, 0, 2304, 512};
    tbl[6] = '{24'h000002, 0, 0, 0, 2304, 512};
    repeat (3) @(posedge clk);
    #1 check(!finish, "reset_finish", int'(finish), 0);
    check(!mem_wren, "reset_wren", int'(mem_wren), 0);
    check(mem_address == 8'd0, "reset_addr", int'(mem_address), 0);
    @(negedge clk) reset = 0;
    begin
      int idle_bad = 0;
      repeat (100) begin
        @(posedge clk) #1;
        if (mem_wren || finish || mem_address != 8'd0) idle_bad++;
      end
      check(idle_bad == 0, "idle_quiet", idle_bad, 0);
    end
    for (int t = 0; t < 7; t++) run(tbl[t]);
    for (int r = 0; r < 3; r++) begin
      vec_t v;
      v = '{24'($urandom), 0, 0, 0, 2304, 512};
      run(v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rc4_shuffle_worker.md
Name: rc4_shuffle_worker

Overview:
- Responder side of the brute-force start/finish handshake. Performs the RC4 key-scheduling swap pass, the "shuffle" stage, on the 256-byte S working memory.
- Runs after the init stage has written s[i]=i.
- Waits for a one-cycle start pulse from the main controller, then runs all 256 iterations of j = j + s[i] + key[i mod 3] followed by swap(s[i], s[j]).
- Signals completion with a one-cycle finish pulse.
- Drives its own memory bus; the controller muxes that bus onto the shared S RAM while the shuffle stage owns it.

Parameters:
- DATA_WIDTH, 8, width of an S memory word and of i/j.
- ADDR_WIDTH, 8, S memory address width (256 entries).
- KEY_WIDTH, 24, secret key width.
- KEY_LENGTH, 3, number of key bytes used cyclically.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start pulse from the main controller.
- secret_key  in  KEY_WIDTH  key under test; byte 0 = secret_key[23:16], byte 2 = secret_key[7:0].
- mem_q  in  DATA_WIDTH  S RAM read data.
- mem_address  out  ADDR_WIDTH  S RAM address.
- mem_data  out  DATA_WIDTH  S RAM write data.
- mem_wren  out  1  S RAM write enable.
- finish  out  1  one-cycle done pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset, and the power-up default:
  - state=IDLE; i=0, j=0, key index k=0.
  - Latched si=0, sj=0.
  - mem_address=0, mem_data=0, mem_wren=0, finish=0.
- RAM timing: synchronous single-port, address/data/wren sampled on the rising edge, mem_q valid in the cycle after the address edge. The block allows one extra wait cycle before capturing mem_q.
- FSM states and transitions (each non-IDLE state lasts exactly one cycle):
  - IDLE: if start, go to READ_I and clear i, j, k. Otherwise stay.
  - READ_I: address=i → WAIT_I.
  - WAIT_I: address=i → CAP_I.
  - CAP_I: si<=mem_q; j<=j+mem_q+keybyte[k] (mod 256) → READ_J.
  - READ_J: address=j → WAIT_J.
  - WAIT_J: address=j → CAP_J.
  - CAP_J: sj<=mem_q → WRITE_I.
  - WRITE_I: address=i, data=sj, wren=1 → WRITE_J.
  - WRITE_J: address=j, data=si, wren=1 → NEXT.
  - NEXT: if i==255, go to DONE. Else i<=i+1, k<=(k==2)?0:k+1, and go to READ_I.
  - DONE: finish=1 → IDLE.
- Arithmetic: all 8-bit, wrapping mod 256. k is a mod-3 counter (no divider).
- Latency: 9 cycles per iteration.
  - Start sampled at edge E0; DONE is entered at edge E0+2304.
  - finish is high for exactly one cycle, then the block returns to IDLE.
- mem_wren is high only in WRITE_I and WRITE_J; never asserted in any other state or during reset.
- Boundary: i==j. WRITE_I writes sj, then WRITE_J writes si to the same address. The final value equals the original s[i], which is the correct self-swap.
- Boundary: j wraps past 255 to the low 8 bits. i does not wrap within a pass; it terminates at 255.
- start while not in IDLE: ignored, with no restart and no effect on i/j.
- start in the DONE cycle: ignored; a new start must arrive while in IDLE.
- secret_key must be stable from start until finish. It is read live each CAP_I, not latched.
- Reset mid-operation: immediate return to IDLE with no further writes and no finish pulse. RAM contents are left partially shuffled; the controller re-runs init.

Decomposition:
- Shared package brute_force_pkg: S_DEPTH=256, KEY_LENGTH=3, and the shuffle state typedef (enum logic [3:0]).
- Key byte selection by k is a small function in the package.
- No sub-module: the block is a single FSM plus datapath registers.

Test Plan:
1. Power-up and reset: hold reset 3 cycles → finish=0, mem_wren=0, mem_address=0. After release with no start, state stays IDLE for 100 cycles with no writes.
2. Key 0x000000 on an S model preloaded s[i]=i, pulse start:
   - iteration 0 gives j=0 (self-swap), iteration 1 gives j=1 (self-swap), iteration 2 gives j=3 and swaps s[2],s[3] (s[2]=3, s[3]=2).
   - Final array matches the software RC4 KSA.
   - finish pulses exactly 2304 cycles after the start edge.
3. Key 0x0249F1: compare the final 256 bytes with the golden RC4 KSA. Also count mem_wren cycles == 512.
4. Extra start pulses at cycles 10 and 1000 of a run → no restart; finish still at 2304 and result unchanged.
5. Assert reset at cycle 500 of a run:
   - no finish; mem_wren=0 from the next cycle; state IDLE.
   - A new init plus start with key 0x000000 gives the correct result.
6. Back-to-back runs, keys 0x000001 then 0x000002, each preceded by re-init:
   - both results match golden.
   - j restarts at 0 each run, and each finish is exactly one cycle wide.
